// File: rtl/uart_rx_fifo_if.sv
// Bus bundle for uart_rx_fifo: receiver byte input, show-ahead pop side and status.
// The master drives receiver/bus strobes; the slave (the FIFO) returns data and status.
interface uart_rx_fifo_if #(
    parameter int unsigned ADDR_W = 4
);
    logic [7:0]      rx_data;
    logic            rx_ready;
    logic            pop;
    logic            clr;
    logic            ovr_clr;
    logic [7:0]      rd_data;
    logic            empty;
    logic            full;
    logic [ADDR_W:0] level;
    logic            overrun;
    logic            irq;

    modport master (
        output rx_data, rx_ready, pop, clr, ovr_clr,
        input  rd_data, empty, full, level, overrun, irq
    );

    modport slave (
        input  rx_data, rx_ready, pop, clr, ovr_clr,
        output rd_data, empty, full, level, overrun, irq
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO: captures one byte per rx_ready rising edge, show-ahead pop, sticky overrun.
// Optional threshold/overrun interrupt register enabled by defining UART_RX_FIFO_IRQ_EN.
module uart_rx_fifo #(
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned THRESHOLD = 8
) (
    input  logic          clk,
    input  logic          rst,
    uart_rx_fifo_if.slave bus
);
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned PW    = ADDR_W + 1;

    // Elaboration-time parameter range checks
    if (ADDR_W < 1 || ADDR_W > 8) begin : g_bad_addr_w
        $error("uart_rx_fifo: ADDR_W out of range 1..8");
    end
    if (THRESHOLD < 1 || THRESHOLD > DEPTH) begin : g_bad_threshold
        $error("uart_rx_fifo: THRESHOLD out of range 1..2**ADDR_W");
    end

    logic [7:0]        mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              rx_ready_q;
    logic              overrun_q;

    logic              empty_c;
    logic              full_c;
    logic              push_c;
    logic              pop_ok_c;
    logic              wr_en_c;
    logic              ovr_ev_c;
    logic [PW-1:0]     level_c;

    // Status and handshake decode, all derived from registered pointers
    always_comb begin
        empty_c  = (wr_ptr == rd_ptr);
        full_c   = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
        level_c  = wr_ptr - rd_ptr;
        push_c   = bus.rx_ready & ~rx_ready_q;
        pop_ok_c = bus.pop & ~empty_c;
        wr_en_c  = push_c & (~full_c | pop_ok_c) & ~bus.clr;
        ovr_ev_c = push_c & full_c & ~bus.pop & ~bus.clr;
    end

    // Pointers, edge detector and sticky overrun
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            rx_ready_q <= 1'b1;
            overrun_q  <= 1'b0;
        end else begin
            rx_ready_q <= bus.rx_ready;
            if (bus.clr) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_en_c) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop_ok_c) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
            end
            if (ovr_ev_c) begin
                overrun_q <= 1'b1;
            end else if (bus.ovr_clr) begin
                overrun_q <= 1'b0;
            end
        end
    end

    // Storage array has no reset; contents are only visible between the pointers
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[wr_ptr[ADDR_W-1:0]] <= bus.rx_data;
        end
    end

    assign bus.rd_data = empty_c ? 8'h00 : mem[rd_ptr[ADDR_W-1:0]];
    assign bus.empty   = empty_c;
    assign bus.full    = full_c;
    assign bus.level   = level_c;
    assign bus.overrun = overrun_q;

`ifdef UART_RX_FIFO_IRQ_EN
    logic irq_q;

    // Interrupt lags the fill/overrun condition by one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= (level_c >= PW'(THRESHOLD)) | overrun_q;
        end
    end

    assign bus.irq = irq_q;
`else
    assign bus.irq = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed scoreboard bench for uart_rx_fifo (ADDR_W=4, THRESHOLD=8).
// Irq expectations follow whether UART_RX_FIFO_IRQ_EN is defined for the build.
module tb_uart_rx_fifo;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DEPTH  = 1 << ADDR_W;
`ifdef UART_RX_FIFO_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    int   vectors;
    int   errors;
    logic [7:0] sb [$];

    uart_rx_fifo_if #(.ADDR_W(ADDR_W)) bus ();

    uart_rx_fifo #(.ADDR_W(ADDR_W), .THRESHOLD(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before 1ms");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One rx_ready pulse; the model accepts the byte only when not full
    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_ready = 1'b1;
        @(negedge clk);
        bus.rx_ready = 1'b0;
        @(negedge clk);
        if (sb.size() < DEPTH) sb.push_back(b);
    endtask

    task automatic pop_one();
        logic [7:0] e;
        e = sb.pop_front();
        chk("rd_data_head", 32'(bus.rd_data), 32'(e));
        bus.pop = 1'b1;
        @(negedge clk);
        bus.pop = 1'b0;
        chk("level_after_pop", 32'(bus.level), 32'(sb.size()));
    endtask

    initial begin
        logic [7:0] e;
        vectors = 0;
        errors  = 0;
        rst = 1'b1;
        bus.rx_data = 8'h00;
        bus.rx_ready = 1'b0;
        bus.pop = 1'b0;
        bus.clr = 1'b0;
        bus.ovr_clr = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_empty",   32'(bus.empty),   32'd1);
        chk("rst_full",    32'(bus.full),    32'd0);
        chk("rst_level",   32'(bus.level),   32'd0);
        chk("rst_overrun", 32'(bus.overrun), 32'd0);
        chk("rst_irq",     32'(bus.irq),     32'd0);
        chk("rst_rd_data", 32'(bus.rd_data), 32'd0);

        // Three bytes, then drain
        send_byte(8'h41);
        chk("first_byte_shown", 32'(bus.rd_data), 32'h41);
        send_byte(8'h42);
        send_byte(8'h43);
        chk("level3", 32'(bus.level), 32'd3);
        repeat (3) pop_one();
        chk("drained_rd_data", 32'(bus.rd_data), 32'd0);
        chk("drained_empty",   32'(bus.empty),   32'd1);

        // Fill to full, 17th byte dropped with overrun
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        chk("full_after_16", 32'(bus.full),    32'd1);
        chk("no_ovr_at_16",  32'(bus.overrun), 32'd0);
        send_byte(8'h10);
        chk("ovr_after_17",   32'(bus.overrun), 32'd1);
        chk("level_after_17", 32'(bus.level),   32'd16);
        repeat (16) pop_one();
        chk("empty_after_16_pops", 32'(bus.empty), 32'd1);

        // Clear overrun, refill, then push+pop on the same edge while full
        bus.ovr_clr = 1'b1;
        @(negedge clk);
        bus.ovr_clr = 1'b0;
        chk("ovr_cleared", 32'(bus.overrun), 32'd0);
        for (int i = 0; i < 16; i++) send_byte(8'(8'h20 + i));
        chk("refull", 32'(bus.full), 32'd1);
        e = sb.pop_front();
        chk("full_head", 32'(bus.rd_data), 32'(e));
        bus.rx_data  = 8'h30;
        bus.rx_ready = 1'b1;
        bus.pop      = 1'b1;
        @(negedge clk);
        bus.pop      = 1'b0;
        bus.rx_ready = 1'b0;
        sb.push_back(8'h30);
        chk("pushpop_full_level", 32'(bus.level),   32'd16);
        chk("pushpop_full_ovr",   32'(bus.overrun), 32'd0);
        @(negedge clk);
        chk("pushpop_full_ovr2",  32'(bus.overrun), 32'd0);
        repeat (16) pop_one();
        chk("wrap_drained_empty", 32'(bus.empty), 32'd1);

        // Pop on empty is ignored
        bus.pop = 1'b1;
        @(negedge clk);
        bus.pop = 1'b0;
        chk("empty_pop_level",   32'(bus.level),   32'd0);
        chk("empty_pop_rd_data", 32'(bus.rd_data), 32'd0);
        chk("empty_pop_ovr",     32'(bus.overrun), 32'd0);

        // clr wins over a same-cycle push
        bus.rx_data  = 8'h55;
        bus.rx_ready = 1'b1;
        bus.clr      = 1'b1;
        @(negedge clk);
        bus.clr      = 1'b0;
        bus.rx_ready = 1'b0;
        @(negedge clk);
        chk("clr_push_level",   32'(bus.level),   32'd0);
        chk("clr_push_rd_data", 32'(bus.rd_data), 32'd0);

        // ovr_clr loses against a same-cycle overrun event
        for (int i = 0; i < 16; i++) send_byte(8'(8'h80 + i));
        send_byte(8'h99);
        chk("ovr_set_again", 32'(bus.overrun), 32'd1);
        bus.rx_data  = 8'h9A;
        bus.rx_ready = 1'b1;
        bus.ovr_clr  = 1'b1;
        @(negedge clk);
        bus.ovr_clr  = 1'b0;
        bus.rx_ready = 1'b0;
        chk("ovr_clr_vs_event", 32'(bus.overrun), 32'd1);
        @(negedge clk);
        chk("ovr_still_set",    32'(bus.overrun), 32'd1);

        // clr flushes content but leaves overrun alone
        bus.clr = 1'b1;
        @(negedge clk);
        bus.clr = 1'b0;
        sb.delete();
        chk("clr_flush_empty", 32'(bus.empty),   32'd1);
        chk("clr_keeps_ovr",   32'(bus.overrun), 32'd1);
        bus.ovr_clr = 1'b1;
        @(negedge clk);
        bus.ovr_clr = 1'b0;
        chk("ovr_clr_alone", 32'(bus.overrun), 32'd0);

        // Threshold interrupt: raises one cycle after level hits 8, drops one cycle after a pop
        for (int i = 0; i < 7; i++) send_byte(8'(8'hA0 + i));
        chk("irq_below_thr", 32'(bus.irq), 32'd0);
        bus.rx_data  = 8'hA7;
        bus.rx_ready = 1'b1;
        @(negedge clk);
        sb.push_back(8'hA7);
        chk("thr_level8",   32'(bus.level), 32'd8);
        chk("irq_lag",      32'(bus.irq),   32'd0);
        bus.rx_ready = 1'b0;
        @(negedge clk);
        chk("irq_raised",   32'(bus.irq),   32'(IRQ_EN));
        bus.pop = 1'b1;
        @(negedge clk);
        bus.pop = 1'b0;
        void'(sb.pop_front());
        chk("thr_level7",   32'(bus.level), 32'd7);
        chk("irq_hold",     32'(bus.irq),   32'(IRQ_EN));
        @(negedge clk);
        chk("irq_dropped",  32'(bus.irq),   32'd0);
        chk("head_after_irq", 32'(bus.rd_data), 32'(sb[0]));

        // Asynchronous reset mid-operation, with rx_ready held high across release
        #2;
        rst = 1'b1;
        bus.rx_ready = 1'b1;
        #1;
        chk("async_rst_empty", 32'(bus.empty), 32'd1);
        chk("async_rst_level", 32'(bus.level), 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("held_ready_empty", 32'(bus.empty), 32'd1);
        chk("held_ready_level", 32'(bus.level), 32'd0);
        bus.rx_ready = 1'b0;
        @(negedge clk);
        chk("held_ready_irq", 32'(bus.irq), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer between the UART receiver and the memory-mapped UART peripheral. Each new byte flagged by the receiver's `rx_ready` level is captured into a circular FIFO. The bus side drains the FIFO at its own pace through a show-ahead pop interface, so software no longer loses bytes between polls. The block also reports fill level, a sticky overrun flag and an optional threshold interrupt.

## Interface
- `ADDR_W`, 4: pointer width; depth = 2**ADDR_W entries; legal range 1..8.
- `THRESHOLD`, 8: irq fill threshold, 1..2**ADDR_W; used only with the macro.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `rx_data`  in  8  byte from receiver; stable while `rx_ready` high.
- `rx_ready`  in  1  receiver byte-valid level; a rising edge marks one new byte.
- `pop`  in  1  single-cycle read strobe; removes head entry.
- `clr`  in  1  synchronous flush.
- `ovr_clr`  in  1  clears sticky overrun.
- `rd_data`  out  8  head entry (show-ahead); 8'h00 when empty.
- `empty`  out  1  no entries.
- `full`  out  1  2**ADDR_W entries.
- `level`  out  ADDR_W+1  current entry count.
- `overrun`  out  1  sticky: a byte arrived while full.
- `irq`  out  1  threshold/overrun interrupt (see Configuration).

## Operation
- Storage: 2**ADDR_W x 8 register array; `wr_ptr` and `rd_ptr` are ADDR_W+1 bits, low ADDR_W bits index, wrap modulo 2**(ADDR_W+1).
- `level` = `wr_ptr - rd_ptr` (ADDR_W+1 bits, unsigned); `empty` = pointers equal; `full` = MSBs differ, low bits equal. All combinational from registers.
- Edge detect: `rx_ready_q` registers `rx_ready`. `push` = `rx_ready & ~rx_ready_q`. `rx_ready_q` resets to 1, so a level already high at reset release is not captured.
- Push, not full (or full with a simultaneous valid pop): write `rx_data` at `wr_ptr`, increment `wr_ptr`.
- Push while full with no pop: byte dropped, pointers unchanged, `overrun` set.
- Pop, not empty: increment `rd_ptr`. Pop while empty: ignored, no state change, no error flag.
- Push and pop together, empty: push only. Not empty: both, `level` unchanged. Full: both, no overrun.
- `clr`: `wr_ptr`=`rd_ptr`=0. Priority over push/pop in the same cycle, and the pushed byte is discarded. `overrun` unaffected.
- `ovr_clr`: clears `overrun`. A same-cycle overrun event wins, so `overrun` stays 1.
- `rd_data` = `mem[rd_ptr]` when not empty, else 8'h00.

## Timing
- Reset values: pointers 0, `empty`=1, `full`=0, `level`=0, `overrun`=0, `irq`=0, `rd_data`=8'h00, `rx_ready_q`=1, memory contents don't-care.
- Reset asserted mid-operation discards all contents immediately (asynchronous).
- Push latency: `rx_ready` first sampled high at edge N, then after N `empty`=0, `level` incremented and `rd_data` shows the byte if the FIFO was empty.
- Pop latency: `pop` sampled at edge N, then after N the next entry appears on `rd_data` and `level` is decremented. Bus may pop every cycle.
- `rx_ready` must go low for at least one sampled cycle between bytes. A level held high counts as one byte.
- `overrun` rises the cycle after the dropped push edge.

## Configuration
- `UART_RX_FIFO_IRQ_EN` defined: `irq` is a register, updated every cycle to (`level` >= `THRESHOLD`) | `overrun`. It lags the condition by one cycle and clears one cycle after the condition clears.
- Not defined: `irq` is tied to 0, no irq register or comparator is built, and `THRESHOLD` is ignored.

## Test plan
- Reset, then 3 bytes 0x41,0x42,0x43 as separate `rx_ready` pulses, then pop 3 times: `rd_data` 0x41→0x42→0x43→0x00, `level` 3→0, `empty`=1.
- ADDR_W=4: push 17 bytes 0x00..0x10 with no pops: `full`=1 after 16th, 17th dropped, `overrun`=1. Pop 16: reads 0x00..0x0F in order.
- Full FIFO, push and pop on same edge: `level` stays 16, `overrun` stays 0, wrapped byte read last.
- Pop on empty, and `clr` with simultaneous push: `level` stays 0, `rd_data`=0x00. Then `ovr_clr` with a simultaneous overrun event: `overrun` remains 1.
- `rx_ready` held high across reset release, then 20 cycles: no byte captured, `empty`=1.
- With `UART_RX_FIFO_IRQ_EN`, THRESHOLD=8: 8th push raises `irq` one cycle later, one pop drops it one cycle later. Without the macro, `irq`=0 throughout.
